if_prefetch_queue: RTL
======================

Name: if_prefetch_queue

Overview:
Parametrised instruction-fetch stage with an internal prefetch queue. It issues sequential fetches to the Memory Controller whenever the queue has space, and yields to MEM accesses. It flushes on an EX jump and presents the oldest buffered {pc, inst} pair to IF_ID under a stall handshake. It sits between PC/EX redirect logic, the Memory Controller and IF_ID.

Parameters:
ADDR_WIDTH, 32, address and PC width
INST_WIDTH, 32, instruction width
DEPTH, 4, queue entries; power of two, >= 2
INST_BYTES, 4, PC increment per fetched instruction
RESET_PC, 0, fetch PC after reset

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  asynchronous, active-low reset
pcJump_in  input  1  EX redirect strobe, 1-cycle pulse
jumpTarget_in  input  ADDR_WIDTH  redirect target, valid with pcJump_in
MEM_MCAccess_in  input  1  MEM owns the Memory Controller this cycle
MC_busy_in  input  1  Memory Controller has a transaction in flight
instE_in  input  1  1-cycle pulse: inst_in holds the fetched word
inst_in  input  INST_WIDTH  fetched instruction
stall_in  input  1  downstream (IF_ID) cannot accept this cycle
MCE_out  output  1  fetch request enable, registered
MCAddr_out  output  ADDR_WIDTH  fetch address, registered
pc_out  output  ADDR_WIDTH  PC of queue head; 0 when empty
inst_out  output  INST_WIDTH  instruction at queue head; 0 when empty
instValid_out  output  1  queue non-empty
ifStall_out  output  1  queue empty; fetch cannot supply an instruction

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=IDLE, fetchPC=RESET_PC, count=0, head/tail pointers=0.
  - MCE_out=0, MCAddr_out=0, pc_out=0, inst_out=0, instValid_out=0, ifStall_out=1.
  - Reset mid-transaction abandons the request; no response is buffered.
- States:
  - IDLE: no request outstanding.
  - WAIT: request issued, awaiting instE_in.
  - DROP: a request was orphaned by a jump; discard its response.
- IDLE -> WAIT when count<DEPTH && !MEM_MCAccess_in && !MC_busy_in && !pcJump_in. At that edge MCE_out<=1 and MCAddr_out<=fetchPC.
- WAIT: MCE_out and MCAddr_out are held stable.
  - On instE_in=1: push {fetchPC, inst_in} at tail; fetchPC<=fetchPC+INST_BYTES (wraps mod 2^ADDR_WIDTH); MCE_out<=0; MCAddr_out<=0; go to IDLE.
  - Minimum spacing: one IDLE cycle between consecutive requests.
  - MEM_MCAccess_in has no effect in WAIT; the Memory Controller arbitrates.
- Jump (pcJump_in=1), highest priority after reset, takes effect in any state:
  - Queue flushed (count=0, pointers reset to 0); fetchPC<=jumpTarget_in; MCE_out<=0; MCAddr_out<=0; no pop occurs that cycle.
  - From WAIT with MC_busy_in=1 and instE_in=0: go to DROP.
  - Otherwise, including instE_in=1 in the same cycle: go to IDLE. A same-cycle response is discarded and fetchPC is not incremented.
- DROP: MCE_out=0.
  - On instE_in=1: discard the data, go to IDLE.
  - If MC_busy_in falls without instE_in: go to IDLE.
  - A further jump while in DROP updates fetchPC only.
- Output/pop:
  - instValid_out = (count!=0); ifStall_out = (count==0).
  - pc_out and inst_out come combinationally from the head entry, and are 0 when empty.
  - Pop at the edge when instValid_out && !stall_in && !pcJump_in.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push on full cannot occur (issue requires count<DEPTH). Implementation adds an assertion.
- Pointer arithmetic is modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.

Test Plan:
- Reset then idle memory (instE_in 2 cycles after each MCE_out): MCAddr_out sequence 0x0, 0x4, 0x8. Head pc_out=0x0 with instValid_out=1 after the first response. ifStall_out=1 until then.
- Queue fill with stall_in=1, DEPTH=4: exactly 4 requests issued (0x0..0xC). MCE_out stays 0 afterwards. Releasing stall_in for one cycle pops pc 0x0 and a request to 0x10 follows.
- MEM priority: MEM_MCAccess_in=1 for 5 cycles in IDLE -> MCE_out stays 0. Request to the current fetchPC issues on the edge after the signal drops.
- Jump while in WAIT with MC_busy_in=1, jumpTarget_in=0x100: queue empties and the stale instE_in response is discarded (DROP). The next MCAddr_out is 0x100 and the first head pc_out is 0x100.
- Jump coincident with instE_in and a pop-eligible head: no push and no pop, count=0. The next request goes to jumpTarget_in.
- Address wrap with RESET_PC=0xFFFFFFFC: first fetch 0xFFFFFFFC, second 0x00000000. Asynchronous reset asserted mid-WAIT clears all outputs immediately.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: issues sequential fetches into a small prefetch queue and
// presents the oldest {pc, inst} pair downstream; flushes on an EX redirect.
module if_prefetch_queue #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           INST_WIDTH = 32,
   parameter int unsigned           DEPTH      = 4,
   parameter int unsigned           INST_BYTES = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  pcJump_in,
   input  logic [ADDR_WIDTH-1:0] jumpTarget_in,
   input  logic                  MEM_MCAccess_in,
   input  logic                  MC_busy_in,
   input  logic                  instE_in,
   input  logic [INST_WIDTH-1:0] inst_in,
   input  logic                  stall_in,
   output logic                  MCE_out,
   output logic [ADDR_WIDTH-1:0] MCAddr_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [INST_WIDTH-1:0] inst_out,
   output logic                  instValid_out,
   output logic                  ifStall_out
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [ADDR_WIDTH-1:0] mc_addr_q;
   logic                  mce_q;
   logic [CntW-1:0]       count_q;
   logic [PtrW-1:0]       head_q;
   logic [PtrW-1:0]       tail_q;

   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];

   logic not_empty;
   logic do_push;
   logic do_pop;
   logic can_issue;

   assign not_empty = (count_q != '0);
   assign do_pop    = not_empty && !stall_in && !pcJump_in;
   assign do_push   = (state_q == StWait) && instE_in && !pcJump_in;
   assign can_issue = (count_q < CntFull) && !MEM_MCAccess_in && !MC_busy_in && !pcJump_in;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         mc_addr_q  <= '0;
         mce_q      <= 1'b0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else if (pcJump_in) begin
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         fetch_pc_q <= jumpTarget_in;
         mce_q      <= 1'b0;
         mc_addr_q  <= '0;
         // A request still in flight must have its response swallowed in StDrop.
         case (state_q)
            StWait:  state_q <= (MC_busy_in && !instE_in) ? StDrop : StIdle;
            StDrop:  state_q <= (instE_in || !MC_busy_in) ? StIdle : StDrop;
            default: state_q <= StIdle;
         endcase
      end else begin
         if (do_push) tail_q <= tail_q + PtrOne;
         if (do_pop)  head_q <= head_q + PtrOne;
         if (do_push && !do_pop) begin
            count_q <= count_q + CntOne;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CntOne;
         end
         case (state_q)
            StIdle: begin
               if (can_issue) begin
                  state_q   <= StWait;
                  mce_q     <= 1'b1;
                  mc_addr_q <= fetch_pc_q;
               end
            end
            StWait: begin
               if (instE_in) begin
                  state_q    <= StIdle;
                  fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(INST_BYTES);
                  mce_q      <= 1'b0;
                  mc_addr_q  <= '0;
               end
            end
            StDrop: begin
               if (instE_in || !MC_busy_in) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Queue storage needs no reset: entries are only visible while count_q covers them.
   always_ff @(posedge clk_in) begin
      if (do_push) begin
         pc_mem[tail_q]   <= fetch_pc_q;
         inst_mem[tail_q] <= inst_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in && do_push) begin
         push_not_full: assert (count_q < CntFull);
      end
   end

   assign MCE_out       = mce_q;
   assign MCAddr_out    = mc_addr_q;
   assign pc_out        = not_empty ? pc_mem[head_q] : '0;
   assign inst_out      = not_empty ? inst_mem[head_q] : '0;
   assign instValid_out = not_empty;
   assign ifStall_out   = !not_empty;

endmodule
